// File: rtl/rr_stream_if.sv
// Signal bundle between bus masters, register slaves and rr_stream_interconnect.
// The interconnect uses the slave modport; the surrounding environment uses master.
interface rr_stream_if #(
    parameter int NUM_M  = 4,
    parameter int NUM_S  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M*DATA_W-1:0] m_data;
    logic [NUM_M-1:0]        m_valid;
    logic [NUM_M-1:0]        m_last;
    logic [NUM_M-1:0]        m_ready;
    logic [NUM_M-1:0]        grant;
    logic [NUM_S*DATA_W-1:0] s_data;
    logic [NUM_S-1:0]        s_valid;
    logic [NUM_S-1:0]        s_ready;
    logic                    dec_err;
    logic                    busy;

    modport master (
        output m_req, m_addr, m_data, m_valid, m_last, s_ready,
        input  m_ready, grant, s_data, s_valid, dec_err, busy
    );

    modport slave (
        input  m_req, m_addr, m_data, m_valid, m_last, s_ready,
        output m_ready, grant, s_data, s_valid, dec_err, busy
    );
endinterface

// File: rtl/rr_stream_interconnect.sv
// N-master x M-slave stream interconnect: registered round-robin grant held for a
// whole burst, exact-match address decode latched at grant, decode-error sink.
module rr_stream_interconnect #(
    parameter int NUM_M  = 4,
    parameter int NUM_S  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [NUM_S*ADDR_W-1:0] SLAVE_ADDR = {8'hBB, 8'hAA}
) (
    input logic      clk,
    input logic      rst,
    rr_stream_if.slave bus
);
    localparam int SEL_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int TGT_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DERR = 2'd2;

    logic [1:0]       state;
    logic [NUM_M-1:0] grant_q;
    logic [SEL_W-1:0] sel;
    logic [TGT_W-1:0] tgt;
    logic [SEL_W-1:0] last_ptr;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [ADDR_W-1:0] pick_addr;
    logic             dec_hit;
    logic [TGT_W-1:0] dec_idx;
    logic             beat_done;
    int               cand;

    // Rotating priority: scan last+1, last+2, ... so the previous winner goes last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int off = 1; off <= NUM_M; off++) begin
            cand = (int'(last_ptr) + off) % NUM_M;
            if (!pick_found && bus.m_req[SEL_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(cand);
            end
        end
    end

    // Descending scan so the lowest matching slave index wins on duplicates.
    always_comb begin
        pick_addr = bus.m_addr[pick_idx*ADDR_W +: ADDR_W];
        dec_hit   = 1'b0;
        dec_idx   = '0;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            if (pick_addr == SLAVE_ADDR[k*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = TGT_W'(k);
            end
        end
    end

    assign beat_done = (state == XFER) ? (bus.m_valid[sel] & bus.s_ready[tgt])
                                       : bus.m_valid[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            sel      <= '0;
            tgt      <= '0;
            last_ptr <= SEL_W'(NUM_M - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q           <= '0;
                        grant_q[pick_idx] <= 1'b1;
                        sel               <= pick_idx;
                        tgt               <= dec_idx;
                        state             <= dec_hit ? XFER : DERR;
                    end
                end
                XFER, DERR: begin
                    if (beat_done && bus.m_last[sel]) begin
                        last_ptr <= sel;
                        grant_q  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure combinational routing; nothing on the data path is registered.
    always_comb begin
        bus.m_ready = '0;
        bus.s_valid = '0;
        bus.s_data  = '0;
        bus.dec_err = 1'b0;
        if (state == XFER) begin
            bus.s_data[tgt*DATA_W +: DATA_W] = bus.m_data[sel*DATA_W +: DATA_W];
            bus.s_valid[tgt]                 = bus.m_valid[sel];
            bus.m_ready[sel]                 = bus.s_ready[tgt];
        end else if (state == DERR) begin
            bus.m_ready[sel] = 1'b1;
            bus.dec_err      = bus.m_valid[sel];
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_rr_stream_interconnect.sv
// Directed bench for rr_stream_interconnect with NUM_M=4, NUM_S=2, slaves at 8'hAA/8'hBB.
module tb_rr_stream_interconnect;
    logic clk;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   handshakes;
    int   pulses;

    rr_stream_if #(.NUM_M(4), .NUM_S(2), .DATA_W(8), .ADDR_W(8)) bus ();

    rr_stream_interconnect #(
        .NUM_M(4), .NUM_S(2), .DATA_W(8), .ADDR_W(8),
        .SLAVE_ADDR({8'hBB, 8'hAA})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int idx, input logic req, input logic [7:0] addr,
                                 input logic [7:0] data, input logic valid, input logic last);
        bus.m_req[idx]          = req;
        bus.m_addr[idx*8 +: 8]  = addr;
        bus.m_data[idx*8 +: 8]  = data;
        bus.m_valid[idx]        = valid;
        bus.m_last[idx]         = last;
    endtask

    task automatic applyReset();
        rst         = 1'b1;
        bus.m_req   = '0;
        bus.m_addr  = '0;
        bus.m_data  = '0;
        bus.m_valid = '0;
        bus.m_last  = '0;
        bus.s_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyReset();
        #1;
        checkOutput("rst_grant", 32'(bus.grant), 'b0000);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_svalid", 32'(bus.s_valid), 'b00);
        checkOutput("rst_mready", 32'(bus.m_ready), 'b0000);

        // Single beat from master 0 to slave 0.
        applyStimulus(0, 1'b1, 8'hAA, 8'h5A, 1'b1, 1'b1);
        bus.s_ready = 2'b01;
        tick();
        checkOutput("t1_grant", 32'(bus.grant), 'b0001);
        checkOutput("t1_svalid", 32'(bus.s_valid), 'b01);
        checkOutput("t1_sdata0", 32'(bus.s_data[7:0]), 'h5A);
        checkOutput("t1_mready", 32'(bus.m_ready), 'b0001);
        checkOutput("t1_busy", 32'(bus.busy), 1);
        bus.m_req = '0;
        tick();
        checkOutput("t1_grant_end", 32'(bus.grant), 'b0000);
        checkOutput("t1_busy_end", 32'(bus.busy), 0);

        // All four request single beats to slave 1: grants rotate with idle bubbles.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 8'hBB, 8'(8'h10 + i), 1'b1, 1'b1);
        bus.s_ready = 2'b10;
        begin
            logic [3:0] exp_grant [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                          4'b0000, 4'b1000, 4'b0000, 4'b0001};
            logic [7:0] exp_data  [9] = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h12,
                                          8'h00, 8'h13, 8'h00, 8'h10};
            for (int c = 0; c < 9; c++) begin
                tick();
                checkOutput($sformatf("rr_grant_%0d", c), 32'(bus.grant), 32'(exp_grant[c]));
                checkOutput($sformatf("rr_sdata1_%0d", c), 32'(bus.s_data[15:8]), 32'(exp_data[c]));
            end
        end

        // Master 2 three-beat burst with a two-cycle stall; master 1 waits.
        applyReset();
        handshakes = 0;
        applyStimulus(2, 1'b1, 8'hBB, 8'hD1, 1'b1, 1'b0);
        bus.s_ready = 2'b10;
        tick();
        checkOutput("b3_grant", 32'(bus.grant), 'b0100);
        checkOutput("b3_mready1", 32'(bus.m_ready), 'b0100);
        checkOutput("b3_data1", 32'(bus.s_data[15:8]), 'hD1);
        if (bus.m_valid[2] && bus.m_ready[2]) handshakes++;
        tick();
        applyStimulus(2, 1'b1, 8'hBB, 8'hD2, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 8'hAA, 8'hE1, 1'b1, 1'b1);
        bus.s_ready = 2'b00;
        #1;
        checkOutput("b3_stall1_mready", 32'(bus.m_ready), 'b0000);
        checkOutput("b3_stall1_svalid", 32'(bus.s_valid), 'b10);
        checkOutput("b3_stall1_grant", 32'(bus.grant), 'b0100);
        if (bus.m_valid[2] && bus.m_ready[2]) handshakes++;
        tick();
        checkOutput("b3_stall2_mready", 32'(bus.m_ready), 'b0000);
        checkOutput("b3_stall2_grant", 32'(bus.grant), 'b0100);
        if (bus.m_valid[2] && bus.m_ready[2]) handshakes++;
        tick();
        bus.s_ready = 2'b10;
        #1;
        checkOutput("b3_beat2_mready", 32'(bus.m_ready), 'b0100);
        checkOutput("b3_beat2_data", 32'(bus.s_data[15:8]), 'hD2);
        if (bus.m_valid[2] && bus.m_ready[2]) handshakes++;
        tick();
        applyStimulus(2, 1'b1, 8'hBB, 8'hD3, 1'b1, 1'b1);
        #1;
        checkOutput("b3_beat3_data", 32'(bus.s_data[15:8]), 'hD3);
        if (bus.m_valid[2] && bus.m_ready[2]) handshakes++;
        tick();
        applyStimulus(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("b3_idle_grant", 32'(bus.grant), 'b0000);
        checkOutput("b3_idle_busy", 32'(bus.busy), 0);
        tick();
        checkOutput("b3_next_grant", 32'(bus.grant), 'b0010);
        checkOutput("b3_next_svalid", 32'(bus.s_valid), 'b01);
        checkOutput("b3_next_sdata0", 32'(bus.s_data[7:0]), 'hE1);
        checkOutput("b3_handshakes", 32'(handshakes), 3);

        // Master 1 to an unmapped address: decode-error sink for two beats.
        applyReset();
        pulses = 0;
        applyStimulus(1, 1'b1, 8'h33, 8'h77, 1'b1, 1'b0);
        bus.s_ready = 2'b11;
        tick();
        checkOutput("de_grant", 32'(bus.grant), 'b0010);
        checkOutput("de_mready", 32'(bus.m_ready), 'b0010);
        checkOutput("de_svalid", 32'(bus.s_valid), 'b00);
        checkOutput("de_err1", 32'(bus.dec_err), 1);
        if (bus.dec_err) pulses++;
        tick();
        bus.m_last[1] = 1'b1;
        #1;
        checkOutput("de_err2", 32'(bus.dec_err), 1);
        checkOutput("de_svalid2", 32'(bus.s_valid), 'b00);
        if (bus.dec_err) pulses++;
        tick();
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("de_err_idle", 32'(bus.dec_err), 0);
        checkOutput("de_busy_idle", 32'(bus.busy), 0);
        checkOutput("de_grant_idle", 32'(bus.grant), 'b0000);
        checkOutput("de_pulses", 32'(pulses), 2);

        // Reset in the middle of a four-beat burst from master 3.
        applyReset();
        applyStimulus(3, 1'b1, 8'hAA, 8'h31, 1'b1, 1'b0);
        bus.s_ready = 2'b01;
        tick();
        checkOutput("mr_grant", 32'(bus.grant), 'b1000);
        checkOutput("mr_mready", 32'(bus.m_ready), 'b1000);
        tick();
        checkOutput("mr_grant_beat2", 32'(bus.grant), 'b1000);
        rst = 1'b1;
        #1;
        checkOutput("mr_rst_grant", 32'(bus.grant), 'b0000);
        checkOutput("mr_rst_svalid", 32'(bus.s_valid), 'b00);
        checkOutput("mr_rst_mready", 32'(bus.m_ready), 'b0000);
        checkOutput("mr_rst_busy", 32'(bus.busy), 0);
        applyStimulus(3, 1'b1, 8'hAA, 8'h32, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 8'hAA, 8'h01, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("mr_after_grant", 32'(bus.grant), 'b0001);
        checkOutput("mr_after_sdata0", 32'(bus.s_data[7:0]), 'h01);

        // Master 0 address change mid-burst must not retarget the burst.
        applyReset();
        applyStimulus(0, 1'b1, 8'hAA, 8'hA1, 1'b1, 1'b0);
        bus.s_ready = 2'b11;
        tick();
        checkOutput("ac_svalid1", 32'(bus.s_valid), 'b01);
        checkOutput("ac_sdata1", 32'(bus.s_data[7:0]), 'hA1);
        tick();
        applyStimulus(0, 1'b1, 8'hBB, 8'hA2, 1'b1, 1'b0);
        #1;
        checkOutput("ac_svalid2", 32'(bus.s_valid), 'b01);
        checkOutput("ac_sdata2", 32'(bus.s_data[7:0]), 'hA2);
        checkOutput("ac_sdata2_s1", 32'(bus.s_data[15:8]), 'h00);
        tick();
        applyStimulus(0, 1'b0, 8'hBB, 8'hA3, 1'b1, 1'b1);
        #1;
        checkOutput("ac_svalid3", 32'(bus.s_valid), 'b01);
        checkOutput("ac_sdata3", 32'(bus.s_data[7:0]), 'hA3);
        tick();
        checkOutput("ac_grant_end", 32'(bus.grant), 'b0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/rr_stream_interconnect.md
Name: rr_stream_interconnect

Overview:
- Parametrised N-master × M-slave interconnect with a registered round-robin arbiter and per-transfer address decode.
- Generalises the fixed 2-master/2-slave arbiter to arbitrary counts and widths.
- Adds locked multi-beat bursts, true rotating priority and a decode-error response path.
- Sits between bus masters and register slaves in the AXI4-Lite subsystem.

Parameters:
- NUM_M, 4: number of masters (2..8).
- NUM_S, 2: number of slaves (1..8).
- DATA_W, 8: data width per channel.
- ADDR_W, 8: address width per master.
- SLAVE_ADDR, {8'hBB,8'hAA}: NUM_S*ADDR_W concatenation; slice k is the exact-match address of slave k.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_req  in  NUM_M  per-master bus request
- m_addr  in  NUM_M*ADDR_W  per-master target address, slice i for master i
- m_data  in  NUM_M*DATA_W  per-master write data
- m_valid  in  NUM_M  per-master data valid
- m_last  in  NUM_M  marks final beat of master's burst
- m_ready  out  NUM_M  ready returned to master
- grant  out  NUM_M  one-hot registered grant
- s_data  out  NUM_S*DATA_W  data to slaves
- s_valid  out  NUM_S  valid to slaves
- s_ready  in  NUM_S  slave ready
- dec_err  out  1  one-cycle pulse on each beat consumed with no matching slave
- busy  out  1  high while any grant is active

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, busy=0, dec_err=0, all m_ready/s_valid/s_data=0, priority pointer last=NUM_M-1 (master 0 highest priority first).
- States:
  - IDLE: if any m_req, pick the first requesting index searching last+1, last+2, … modulo NUM_M. Register grant onehot, latch sel=index, latch tgt=decode(m_addr[sel]) (slave index, or ERR if no slice matches; lowest k wins on duplicate addresses). Go to XFER, or DERR if ERR. Else stay.
  - XFER: route s_data[tgt]=m_data[sel], s_valid[tgt]=m_valid[sel], m_ready[sel]=s_ready[tgt]. Every other s_valid/s_data/m_ready=0. A beat completes when m_valid[sel]&s_ready[tgt]. On a completed beat with m_last[sel]=1: last<=sel, grant<=0, go IDLE.
  - DERR: m_ready[sel]=1, no s_valid. Each beat with m_valid[sel] pulses dec_err the same cycle (combinational). On a beat with m_last, return to IDLE as in XFER.
- Latency:
  - Request sampled in cycle t; grant visible t+1; first beat may complete t+1.
  - After the last beat at cycle t, grant=0 at t+1 (IDLE); next grant at t+2 earliest (one idle bubble is mandatory).
- Arbitration and routing rules:
  - Grant is held for the whole burst; m_req deassertion mid-burst is ignored.
  - m_addr is sampled only at grant; later changes are ignored.
  - A non-selected master's m_valid has no effect.
  - s_ready of a non-target slave is ignored.
  - busy = (state != IDLE).
- Fairness: with all masters requesting continuously, grants cycle 0,1,…,NUM_M-1,0; no master waits more than NUM_M-1 bursts.
- Reset mid-burst: outputs drop to 0 asynchronously and the pointer resets; the partial burst is abandoned and not resumed.
- Data is never registered; a held-off beat (valid without ready) keeps data stable only as long as the master holds it.

Test Plan:
- Reset, then m_req=4'b0001, m_addr[0]=8'hAA, one beat data 8'h5A, last=1, s_ready[0]=1 → grant=0001 at t+1; s_valid[0]=1, s_data[0]=8'h5A, m_ready[0]=1; grant=0 at t+2.
- m_req=4'b1111 held continuously, every burst 1 beat to 8'hBB → grant sequence 0001,0010,0100,1000,0001, each separated by one idle cycle.
- Master 2 3-beat burst to 8'hBB with s_ready[1] low for 2 cycles on beat 2 → m_ready[2]=0 while stalled; exactly 3 handshakes; m_req[1] asserted mid-burst is not granted until burst ends.
- Master 1 addr 8'h33 (no match), 2 beats → no s_valid asserted; m_ready[1]=1; dec_err pulses twice; returns to IDLE.
- rst asserted during beat 2 of a 4-beat burst from master 3 → grant, s_valid, m_ready 0 immediately; after release with m_req=1001, master 0 is granted first.
- Master 0 changes m_addr from 8'hAA to 8'hBB mid-burst → all beats still go to slave 0.
